// File: rtl/st_m_ss_meter_if.sv
// Sync-strobe meter bus: async strobe/tick inputs toward the meter, measured codes back.
// master drives the strobes and reads results; slave is the meter itself.
interface st_m_ss_meter_if #(
    parameter int CW = 16
);
    logic          T8us;
    logic          Tnc;
    logic          Tni;
    logic          Tki;
    logic          Tnp;
    logic          Tkp;
    logic [CW-1:0] Mni;
    logic [CW-1:0] Mii;
    logic [CW-1:0] Mnp;
    logic [CW-1:0] Mip;
    logic          meas_valid;
    logic          err_order;
    logic          err_miss;
    logic          err_ovf;

    modport master (
        output T8us, Tnc, Tni, Tki, Tnp, Tkp,
        input  Mni, Mii, Mnp, Mip, meas_valid, err_order, err_miss, err_ovf
    );

    modport slave (
        input  T8us, Tnc, Tni, Tki, Tnp, Tkp,
        output Mni, Mii, Mnp, Mip, meas_valid, err_order, err_miss, err_ovf
    );
endinterface

// File: rtl/st_m_ss_meter.sv
// Measures Tni/Tki/Tnp/Tkp strobe timing in 8 us ticks relative to Tnc; publishes once per cycle.
// Latency: input edge seen 3 clk after first high sample; results 1 clk after closing Tnc edge.
module st_m_ss_meter #(
    parameter int CW       = 16,
    parameter int SYNC_LEN = 3
) (
    input logic            clk,
    input logic            rst,
    st_m_ss_meter_if.slave sif
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] W_NI = 3'd1;
    localparam logic [2:0] W_KI = 3'd2;
    localparam logic [2:0] W_NP = 3'd3;
    localparam logic [2:0] W_KP = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [CW-1:0] TMAX = '1;

    logic [5:0]                async_in;
    logic [5:0][SYNC_LEN-1:0] sync_f;
    logic [5:0]                edge_r;
    logic                      e_tick, e_nc;
    logic [3:0]                strb;

    logic [2:0]    state;
    logic [CW-1:0] tik;
    logic [CW-1:0] cap_ni, cap_ki, cap_np, cap_kp;
    logic          ord_c, ovf_c;

    logic [2:0]    wst;
    logic [CW-1:0] wtik;
    logic [3:0]    exp_vec;
    logic          hit, other, active;

    assign async_in = {sif.Tkp, sif.Tnp, sif.Tki, sif.Tni, sif.Tnc, sif.T8us};
    assign e_tick   = edge_r[0];
    assign e_nc     = edge_r[1];
    assign strb     = edge_r[5:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_f <= '0;
            edge_r <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                sync_f[i] <= {sync_f[i][SYNC_LEN-2:0], async_in[i]};
                edge_r[i] <= (sync_f[i] == SYNC_LEN'(3));
            end
        end
    end

    // A strobe coincident with Tnc is judged against the new cycle: state W_NI, tik 0.
    always_comb begin
        wst     = e_nc ? W_NI : state;
        wtik    = e_nc ? '0 : tik;
        exp_vec = 4'b0000;
        case (wst)
            W_NI:    exp_vec = 4'b0001;
            W_KI:    exp_vec = 4'b0010;
            W_NP:    exp_vec = 4'b0100;
            W_KP:    exp_vec = 4'b1000;
            default: exp_vec = 4'b0000;
        endcase
        hit    = |(strb & exp_vec);
        other  = |(strb & ~exp_vec);
        active = e_nc || (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tik            <= '0;
            cap_ni         <= '0;
            cap_ki         <= '0;
            cap_np         <= '0;
            cap_kp         <= '0;
            ord_c          <= 1'b0;
            ovf_c          <= 1'b0;
            sif.Mni        <= '0;
            sif.Mii        <= '0;
            sif.Mnp        <= '0;
            sif.Mip        <= '0;
            sif.meas_valid <= 1'b0;
            sif.err_order  <= 1'b0;
            sif.err_miss   <= 1'b0;
            sif.err_ovf    <= 1'b0;
        end else begin
            sif.meas_valid <= 1'b0;
            if (e_nc && state != IDLE) begin
                sif.Mni        <= cap_ni;
                sif.Mii        <= cap_ki - cap_ni;
                sif.Mnp        <= cap_np;
                sif.Mip        <= cap_kp - cap_np;
                sif.err_order  <= ord_c;
                sif.err_ovf    <= ovf_c;
                sif.err_miss   <= (state != DONE);
                sif.meas_valid <= 1'b1;
            end
            if (e_nc) begin
                tik    <= '0;
                cap_ni <= '0;
                cap_ki <= '0;
                cap_np <= '0;
                cap_kp <= '0;
                ord_c  <= 1'b0;
                ovf_c  <= 1'b0;
                state  <= W_NI;
            end else if (state != IDLE && e_tick && tik != TMAX) begin
                tik <= tik + CW'(1);
                if (tik == TMAX - CW'(1))
                    ovf_c <= 1'b1;
            end
            // Later assignments here override the new-cycle clears above.
            if (active) begin
                if (other)
                    ord_c <= 1'b1;
                if (hit) begin
                    case (wst)
                        W_NI: begin cap_ni <= wtik; state <= W_KI; end
                        W_KI: begin cap_ki <= wtik; state <= W_NP; end
                        W_NP: begin cap_np <= wtik; state <= W_KP; end
                        W_KP: begin cap_kp <= wtik; state <= DONE; end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_st_m_ss_meter.sv
// Bench for st_m_ss_meter: directed table, corner sequences and random traffic vs a cycle-level model.
module tb_st_m_ss_meter;
    localparam logic [5:0] TICK = 6'b000001;
    localparam logic [5:0] NC   = 6'b000010;
    localparam logic [5:0] NI   = 6'b000100;
    localparam logic [5:0] KI   = 6'b001000;
    localparam logic [5:0] NP   = 6'b010000;
    localparam logic [5:0] KP   = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_tick = 0, in_nc = 0, in_ni = 0, in_ki = 0, in_np = 0, in_kp = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    st_m_ss_meter_if #(.CW(16)) bus16 ();
    st_m_ss_meter_if #(.CW(8))  bus8 ();

    assign bus16.T8us = in_tick; assign bus8.T8us = in_tick;
    assign bus16.Tnc  = in_nc;   assign bus8.Tnc  = in_nc;
    assign bus16.Tni  = in_ni;   assign bus8.Tni  = in_ni;
    assign bus16.Tki  = in_ki;   assign bus8.Tki  = in_ki;
    assign bus16.Tnp  = in_np;   assign bus8.Tnp  = in_np;
    assign bus16.Tkp  = in_kp;   assign bus8.Tkp  = in_kp;

    st_m_ss_meter #(.CW(16), .SYNC_LEN(3)) dut  (.clk(clk), .rst(rst), .sif(bus16.slave));
    st_m_ss_meter #(.CW(8),  .SYNC_LEN(3)) dut8 (.clk(clk), .rst(rst), .sif(bus8.slave));

    typedef struct {
        logic [15:0] mni, mii, mnp, mip;
        logic        ord, miss, ovf;
    } pub_t;

    // Model: index 0 = 16-bit meter, 1 = 8-bit meter.
    pub_t q [2][$];
    int   m_n [2];
    int   m_cap [2][4];
    int   m_next [2];
    bit   m_ord [2], m_ovf [2], m_started [2];

    pub_t last [2];
    int   pub_cnt [2] = '{0, 0};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_started[w] = 0;
            q[w].delete();
        end
    endtask

    task automatic model_step(input logic [5:0] m);
        for (int w = 0; w < 2; w++) begin
            int   mx;
            pub_t p;
            bit   took;
            bit   stray;
            mx = (w == 0) ? 65535 : 255;
            if (m[1]) begin
                if (m_started[w]) begin
                    p.mni  = 16'(m_cap[w][0]);
                    p.mii  = 16'(m_cap[w][1] - m_cap[w][0]) & 16'(mx);
                    p.mnp  = 16'(m_cap[w][2]);
                    p.mip  = 16'(m_cap[w][3] - m_cap[w][2]) & 16'(mx);
                    p.ord  = m_ord[w];
                    p.miss = (m_next[w] != 4);
                    p.ovf  = m_ovf[w];
                    q[w].push_back(p);
                end
                m_started[w] = 1;
                m_n[w] = 0;
                m_next[w] = 0;
                m_ord[w] = 0;
                m_ovf[w] = 0;
                for (int k = 0; k < 4; k++) m_cap[w][k] = 0;
            end
            if (m_started[w]) begin
                took  = 0;
                stray = 0;
                for (int k = 0; k < 4; k++) begin
                    if (m[2+k]) begin
                        if (k == m_next[w]) took = 1;
                        else stray = 1;
                    end
                end
                if (stray) m_ord[w] = 1;
                if (took) begin
                    m_cap[w][m_next[w]] = m_n[w];
                    m_next[w]++;
                end
                if (m[0] && !m[1] && m_n[w] < mx) begin
                    m_n[w]++;
                    if (m_n[w] == mx) m_ovf[w] = 1;
                end
            end
        end
    endtask

    task automatic fire(input logic [5:0] m);
        model_step(m);
        @(negedge clk);
        {in_kp, in_np, in_ki, in_ni, in_nc, in_tick} = m;
        repeat (2) @(negedge clk);
        {in_kp, in_np, in_ki, in_ni, in_nc, in_tick} = 6'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic close_and_wait(input string nm);
        int c0;
        c0 = pub_cnt[0];
        fire(NC);
        for (int i = 0; i < 20 && pub_cnt[0] == c0; i++) @(negedge clk);
        check({nm, "_pub"}, 64'(pub_cnt[0] - c0), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus16.meas_valid) begin
                last[0] = '{bus16.Mni, bus16.Mii, bus16.Mnp, bus16.Mip,
                            bus16.err_order, bus16.err_miss, bus16.err_ovf};
                pub_cnt[0]++;
                if (q[0].size() == 0) check("unexpected_pub16", 64'd1, 64'd0);
                else begin
                    pub_t e;
                    e = q[0].pop_front();
                    check("model16_M", {last[0].mni, last[0].mii, last[0].mnp, last[0].mip},
                          {e.mni, e.mii, e.mnp, e.mip});
                    check("model16_err", {last[0].ord, last[0].miss, last[0].ovf}, {e.ord, e.miss, e.ovf});
                end
            end
            if (bus8.meas_valid) begin
                last[1] = '{16'(bus8.Mni), 16'(bus8.Mii), 16'(bus8.Mnp), 16'(bus8.Mip),
                            bus8.err_order, bus8.err_miss, bus8.err_ovf};
                pub_cnt[1]++;
                if (q[1].size() == 0) check("unexpected_pub8", 64'd1, 64'd0);
                else begin
                    pub_t e;
                    e = q[1].pop_front();
                    check("model8_M", {last[1].mni, last[1].mii, last[1].mnp, last[1].mip},
                          {e.mni, e.mii, e.mnp, e.mip});
                    check("model8_err", {last[1].ord, last[1].miss, last[1].ovf}, {e.ord, e.miss, e.ovf});
                end
            end
        end
    end

    typedef struct {
        int          pos [4];
        int          ticks;
        bit          merge;
        logic [15:0] mni, mii, mnp, mip;
        logic        ord, miss;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int   c0;
        tbl[0] = '{'{5, 25, 30, 120}, 125, 1'b0, 16'd5, 16'd20, 16'd30, 16'd90, 1'b0, 1'b0};
        tbl[1] = '{'{5, 25, 30, -1},  125, 1'b0, 16'd5, 16'd20, 16'd30, 16'hFFE2, 1'b0, 1'b1};
        tbl[2] = '{'{7, 9, 10, 12},   15,  1'b1, 16'd7, 16'd2, 16'd10, 16'd2, 1'b0, 1'b0};
        tbl[3] = '{'{3, 3, -1, -1},   6,   1'b0, 16'd3, 16'hFFFD, 16'd0, 16'd0, 1'b1, 1'b1};

        model_reset();
        repeat (4) @(negedge clk);
        check("reset_M16", {bus16.Mni, bus16.Mii, bus16.Mnp, bus16.Mip}, 64'd0);
        check("reset_flags16", {bus16.meas_valid, bus16.err_order, bus16.err_miss, bus16.err_ovf}, 64'd0);
        rst = 1'b0;

        // First Tnc after reset opens a cycle without publishing.
        c0 = pub_cnt[0];
        fire(NC);
        repeat (6) @(negedge clk);
        check("first_nc_silent", 64'(pub_cnt[0] - c0), 64'd0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k <= tbl[r].ticks; k++) begin
                logic [5:0] s;
                s = 6'b0;
                for (int j = 0; j < 4; j++)
                    if (tbl[r].pos[j] == k) s[2+j] = 1'b1;
                if (k < tbl[r].ticks) begin
                    if (tbl[r].merge && s != 6'b0) fire(s | TICK);
                    else begin
                        if (s != 6'b0) fire(s);
                        fire(TICK);
                    end
                end else if (s != 6'b0) fire(s);
            end
            close_and_wait($sformatf("tbl%0d", r));
            check($sformatf("tbl%0d_Mni", r), 64'(last[0].mni), 64'(tbl[r].mni));
            check($sformatf("tbl%0d_Mii", r), 64'(last[0].mii), 64'(tbl[r].mii));
            check($sformatf("tbl%0d_Mnp", r), 64'(last[0].mnp), 64'(tbl[r].mnp));
            check($sformatf("tbl%0d_Mip", r), 64'(last[0].mip), 64'(tbl[r].mip));
            check($sformatf("tbl%0d_err", r), {last[0].ord, last[0].miss, last[0].ovf},
                  {tbl[r].ord, tbl[r].miss, 1'b0});
        end

        // Out-of-order Tnp is ignored, later strobes still captured.
        repeat (2) fire(TICK);
        fire(NI); repeat (2) fire(TICK);
        fire(NP); fire(TICK);
        fire(KI); fire(TICK);
        fire(NP); fire(TICK);
        fire(KP); fire(TICK);
        close_and_wait("order");
        check("order_M", {last[0].mni, last[0].mii, last[0].mnp, last[0].mip},
              {16'd2, 16'd3, 16'd6, 16'd1});
        check("order_err", {last[0].ord, last[0].miss, last[0].ovf}, 3'b100);

        // Tnc with T8us: tick dropped; Tnc with Tni: Tni lands at tik 0 of the new cycle.
        fire(NC | TICK);
        fire(NI);
        c0 = pub_cnt[0];
        fire(NC | NI);
        for (int i = 0; i < 20 && pub_cnt[0] == c0; i++) @(negedge clk);
        check("nc_tick_Mni", {last[0].mni, 15'd0, last[0].miss}, {16'd0, 15'd0, 1'b1});
        fire(TICK); fire(KI); fire(TICK); fire(NP); fire(TICK); fire(KP);
        close_and_wait("nc_ni");
        check("nc_ni_M", {last[0].mni, last[0].mii, last[0].mnp, last[0].mip},
              {16'd0, 16'd1, 16'd2, 16'd1});
        check("nc_ni_err", {last[0].ord, last[0].miss, last[0].ovf}, 3'b000);

        // Saturation: the 8-bit meter pegs at 255, the 16-bit one keeps counting.
        repeat (280) fire(TICK);
        fire(NI);
        repeat (20) fire(TICK);
        close_and_wait("ovf");
        check("ovf8_Mni", 64'(last[1].mni), 64'hFF);
        check("ovf8_flag", 64'(last[1].ovf), 64'd1);
        check("ovf16_Mni", 64'(last[0].mni), 64'd280);
        check("ovf16_flag", 64'(last[0].ovf), 64'd0);

        // Reset in W_NP clears outputs at once and discards the cycle.
        fire(NI); fire(TICK); fire(KI);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_M16", {bus16.Mni, bus16.Mii, bus16.Mnp, bus16.Mip}, 64'd0);
        check("rst_flags16", {bus16.meas_valid, bus16.err_order, bus16.err_miss, bus16.err_ovf}, 64'd0);
        check("rst_M8", {bus8.Mni, bus8.Mii, bus8.Mnp, bus8.Mip}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        c0 = pub_cnt[0];
        fire(NC);
        repeat (8) @(negedge clk);
        check("post_rst_silent", 64'(pub_cnt[0] - c0), 64'd0);
        fire(TICK); fire(NI); fire(TICK); fire(KI); fire(NP); fire(KP);
        close_and_wait("post_rst");
        check("post_rst_M", {last[0].mni, last[0].mii, last[0].mnp, last[0].mip},
              {16'd1, 16'd1, 16'd2, 16'd0});
        check("post_rst_err", {last[0].ord, last[0].miss, last[0].ovf}, 3'b000);

        // Random traffic, checked against the model by the monitor.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] m;
            m = 6'b0;
            if ($urandom_range(1, 0) == 1) m |= TICK;
            for (int j = 0; j < 4; j++)
                if ($urandom_range(5, 0) == 0) m[2+j] = 1'b1;
            if ($urandom_range(24, 0) == 0) m |= NC;
            if (m == 6'b0) m = TICK;
            fire(m);
        end
        fire(NC);
        repeat (10) @(negedge clk);
        check("drain16", 64'(q[0].size()), 64'd0);
        check("drain8", 64'(q[1].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
